sub_arbiter: RTL

- Round-robin controller that shares one external 32-bit combinational subtractor (a - b) among NUM_REQ requesters.
- Accepts one operand pair at a time and drives registered operands to the subtractor.
- Captures the difference plus a borrow flag and returns them to the winning requester over a valid/ready response channel.
- Sits between requester blocks and the single subtractor instance in the datapath.

---
 rtl/sub_pkg.sv | 12 +
 rtl/sub_arbiter_rr_pick.sv | 30 +++
 rtl/sub_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types for the subtractor arbiter: operand width and the controller state encoding.
package sub_pkg;

   localparam int SUB_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sub_arb_state_t;

endpackage

// File: rtl/sub_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (!any && req[c[IDX_W-1:0]]) begin
            any                = 1'b1;
            grant[c[IDX_W-1:0]] = 1'b1;
            idx                = c[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin sharing of one external combinational subtractor among NUM_REQ requesters.
// Optional counters stat_ops/stat_borrows are built when SUB_ARB_STATS_EN is defined.
module sub_arbiter
   import sub_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = SUB_WIDTH,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         sub_a,
   output logic [WIDTH-1:0]         sub_b,
   input  logic [WIDTH-1:0]         sub_result,
   output logic [NUM_REQ-1:0]       resp_valid,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]         resp_result,
   output logic                     resp_borrow,
   output logic                     busy
`ifdef SUB_ARB_STATS_EN
   ,
   output logic [31:0]              stat_ops,
   output logic [31:0]              stat_borrows
`endif
);

   sub_arb_state_t       state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, gnt_q, pick_idx;
   logic [NUM_REQ-1:0]   pick_grant;
   logic                 pick_any;
   logic                 accept, resp_hs;
   logic [WIDTH-1:0]     a_arr [NUM_REQ];
   logic [WIDTH-1:0]     b_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign accept     = (state_q == IDLE) && pick_any;
   // Gated by rst_n so every output reads 0 while reset is held, even with requests pending.
   assign req_ready  = ((state_q == IDLE) && rst_n) ? pick_grant : '0;
   assign resp_hs    = (state_q == RESP) && resp_ready[gnt_q];
   assign resp_valid = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (resp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         gnt_q       <= '0;
         sub_a       <= '0;
         sub_b       <= '0;
         resp_result <= '0;
         resp_borrow <= 1'b0;
      end else begin
         if (accept) begin
            sub_a <= a_arr[pick_idx];
            sub_b <= b_arr[pick_idx];
            gnt_q <= pick_idx;
            ptr_q <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
         end
         // Borrow comes from our own compare so it does not depend on the subtractor's flags.
         if (state_q == EXEC) begin
            resp_result <= sub_result;
            resp_borrow <= (sub_a < sub_b);
         end
      end
   end

`ifdef SUB_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops     <= '0;
         stat_borrows <= '0;
      end else if (resp_hs) begin
         stat_ops <= stat_ops + 32'd1;
         if (resp_borrow) stat_borrows <= stat_borrows + 32'd1;
      end
   end
`endif

endmodule
